// File: rtl/register_file_pkg.sv
// register_file_pkg
//   Shared constants for the register file: data width default, the funsel
//   operation encoding and the read-select encoding of both output ports.
package register_file_pkg;

  localparam int RF_NBITS_DEFAULT = 16;
  localparam int RF_NUM_REGS      = 8;

  // funsel encoding
  localparam logic [1:0] FUNSEL_CLEAR = 2'b00;
  localparam logic [1:0] FUNSEL_LOAD  = 2'b01;
  localparam logic [1:0] FUNSEL_DEC   = 2'b10;
  localparam logic [1:0] FUNSEL_INC   = 2'b11;

  // osel encoding; the value doubles as the storage index inside the top
  localparam logic [2:0] OSEL_T1 = 3'b000;
  localparam logic [2:0] OSEL_T2 = 3'b001;
  localparam logic [2:0] OSEL_T3 = 3'b010;
  localparam logic [2:0] OSEL_T4 = 3'b011;
  localparam logic [2:0] OSEL_R1 = 3'b100;
  localparam logic [2:0] OSEL_R2 = 3'b101;
  localparam logic [2:0] OSEL_R3 = 3'b110;
  localparam logic [2:0] OSEL_R4 = 3'b111;

endpackage

// File: rtl/register_file_rf_cell.sv
// rf_cell
//   One NBits storage register. When enabled, applies funsel at the rising
//   clock edge (clear / load / decrement / increment, wrapping modulo
//   2^NBits); holds otherwise. Asynchronous active-high reset to zero.
//
//   clk       in   clock
//   rst       in   async reset, active high
//   i_en      in   update enable
//   i_funsel  in   operation select
//   i_d       in   load data
//   o_q       out  stored value
module rf_cell
  import register_file_pkg::*;
#(
  parameter int NBits = RF_NBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [1:0]       i_funsel,
  input  logic [NBits-1:0] i_d,
  output logic [NBits-1:0] o_q
);

  logic [NBits-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      case (i_funsel)
        FUNSEL_CLEAR: r_q <= '0;
        FUNSEL_LOAD:  r_q <= i_d;
        FUNSEL_DEC:   r_q <= r_q - 1'b1;
        FUNSEL_INC:   r_q <= r_q + 1'b1;
        default:      r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/register_file.sv
// register_file
//   Eight NBits registers (T1..T4, R1..R4) sharing one operation select and
//   one load bus, each with its own enable. Two combinational read ports,
//   no write bypass.
//
//   clk     in   clock
//   rst     in   async reset, active high; zeroes every register
//   funsel  in   operation for all enabled registers
//   rsel    in   enables for R1..R4 (bit0 = R1)
//   tsel    in   enables for T1..T4 (bit0 = T1)
//   i       in   load data
//   osel_a  in   read select, port A (000..011 = T1..T4, 100..111 = R1..R4)
//   osel_b  in   read select, port B
//   out_a   out  register chosen by osel_a
//   out_b   out  register chosen by osel_b
module register_file
  import register_file_pkg::*;
#(
  parameter int NBits = RF_NBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       funsel,
  input  logic [3:0]       rsel,
  input  logic [3:0]       tsel,
  input  logic [NBits-1:0] i,
  input  logic [2:0]       osel_a,
  input  logic [2:0]       osel_b,
  output logic [NBits-1:0] out_a,
  output logic [NBits-1:0] out_b
);

  // Storage index equals the osel code: T1..T4 at 0..3, R1..R4 at 4..7.
  logic [NBits-1:0]       w_q [RF_NUM_REGS];
  logic [RF_NUM_REGS-1:0] w_en;

  assign w_en = {rsel, tsel};

  for (genvar g = 0; g < RF_NUM_REGS; g++) begin : g_cell
    rf_cell #(
      .NBits(NBits)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .i_en     (w_en[g]),
      .i_funsel (funsel),
      .i_d      (i),
      .o_q      (w_q[g])
    );
  end

  always_comb begin
    out_a = w_q[osel_a];
    out_b = w_q[osel_b];
  end

endmodule

// File: tb/tb_register_file.sv
`timescale 1ns/100ps
module tb_register_file;
  import register_file_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  funsel;
  logic [3:0]  rsel;
  logic [3:0]  tsel;
  logic [15:0] i;
  logic [2:0]  osel_a;
  logic [2:0]  osel_b;
  logic [15:0] out_a;
  logic [15:0] out_b;

  register_file #(.NBits(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .funsel (funsel),
    .rsel   (rsel),
    .tsel   (tsel),
    .i      (i),
    .osel_a (osel_a),
    .osel_b (osel_b),
    .out_a  (out_a),
    .out_b  (out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model, indexed by osel code
  logic [15:0] m [8];

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [1:0]  fs;
    logic [3:0]  rs;
    logic [3:0]  ts;
    logic [15:0] d;
  } vec_t;
  vec_t vecs[12];

  task automatic model_apply(input logic [1:0] fs, input logic [3:0] rs,
                             input logic [3:0] ts, input logic [15:0] d);
    logic [7:0] en;
    en = {rs, ts};
    for (int k = 0; k < 8; k++) begin
      if (en[k]) begin
        case (fs)
          2'b00: m[k] = 16'h0000;
          2'b01: m[k] = d;
          2'b10: m[k] = m[k] - 16'd1;
          default: m[k] = m[k] + 16'd1;
        endcase
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m[k] = 16'h0000;
  endtask

  // push expectations, select, let the mux settle, then pop and compare
  task automatic expect_ab(input string nm, input logic [2:0] sa, input logic [2:0] sb,
                           input logic [15:0] ea, input logic [15:0] eb);
    sb_t e;
    sb_q.push_back('{name: {nm, "_a"}, exp: ea});
    sb_q.push_back('{name: {nm, "_b"}, exp: eb});
    osel_a = sa;
    osel_b = sb;
    #1;
    e = sb_q.pop_front();
    checks++;
    if (out_a !== e.exp) begin
      failures++;
      $display("FAIL %s osel=%0d got=%h want=%h", e.name, sa, out_a, e.exp);
    end
    e = sb_q.pop_front();
    checks++;
    if (out_b !== e.exp) begin
      failures++;
      $display("FAIL %s osel=%0d got=%h want=%h", e.name, sb, out_b, e.exp);
    end
  endtask

  task automatic check_model(input string nm);
    for (int k = 0; k < 8; k++) begin
      logic [2:0] sa, sb;
      sa = 3'(k);
      sb = 3'(7 - k);
      expect_ab(nm, sa, sb, m[sa], m[sb]);
    end
  endtask

  // one enabled operation on one edge; enables dropped afterwards
  task automatic do_op(input logic [1:0] fs, input logic [3:0] rs,
                       input logic [3:0] ts, input logic [15:0] d);
    @(negedge clk);
    funsel = fs;
    rsel   = rs;
    tsel   = ts;
    i      = d;
    @(posedge clk);
    #1;
    model_apply(fs, rs, ts, d);
    rsel = 4'b0000;
    tsel = 4'b0000;
    i    = 16'hDEAD;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst    = 1'b0;
    funsel = FUNSEL_CLEAR;
    rsel   = 4'b0000;
    tsel   = 4'b0000;
    i      = 16'h0000;
    osel_a = OSEL_T1;
    osel_b = OSEL_T1;
    model_reset();

    vecs[0]  = '{FUNSEL_LOAD,  4'b1010, 4'b0101, 16'h1357};
    vecs[1]  = '{FUNSEL_INC,   4'b1111, 4'b0000, 16'h0000};
    vecs[2]  = '{FUNSEL_DEC,   4'b0001, 4'b1000, 16'h0000};
    vecs[3]  = '{FUNSEL_LOAD,  4'b0100, 4'b0010, 16'hFFFF};
    vecs[4]  = '{FUNSEL_INC,   4'b0100, 4'b0010, 16'h0000};
    vecs[5]  = '{FUNSEL_CLEAR, 4'b1000, 4'b0001, 16'h5555};
    vecs[6]  = '{FUNSEL_DEC,   4'b1111, 4'b1111, 16'h0000};
    vecs[7]  = '{FUNSEL_LOAD,  4'b0000, 4'b0000, 16'hBEEF};
    for (int v = 8; v < 12; v++) begin
      vecs[v].fs = 2'($urandom_range(0, 3));
      vecs[v].rs = 4'($urandom_range(0, 15));
      vecs[v].ts = 4'($urandom_range(0, 15));
      vecs[v].d  = 16'($urandom);
    end

    // async reset pulse with no clock edge, then sweep port A
    #1 rst = 1'b1;
    expect_ab("rst_high", OSEL_T1, OSEL_R4, 16'h0000, 16'h0000);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic [2:0] s;
      s = 3'(k);
      expect_ab("rst_sweep", s, s, 16'h0000, 16'h0000);
    end

    // load and read
    do_op(FUNSEL_LOAD, 4'b0001, 4'b0000, 16'h1234);
    do_op(FUNSEL_LOAD, 4'b0000, 4'b1000, 16'hABCD);
    expect_ab("load_read", OSEL_R1, OSEL_T4, 16'h1234, 16'hABCD);

    // decrement / increment wrap on R2
    do_op(FUNSEL_DEC, 4'b0010, 4'b0000, 16'h0000);
    expect_ab("wrap_dec", OSEL_R2, OSEL_R2, 16'hFFFF, 16'hFFFF);
    do_op(FUNSEL_INC, 4'b0010, 4'b0000, 16'h0000);
    expect_ab("wrap_inc", OSEL_R2, OSEL_R1, 16'h0000, 16'h1234);

    // multi-enable
    do_op(FUNSEL_LOAD, 4'b1111, 4'b1111, 16'h0005);
    do_op(FUNSEL_INC, 4'b1111, 4'b0000, 16'h0000);
    expect_ab("multi_r12", OSEL_R1, OSEL_R2, 16'h0006, 16'h0006);
    expect_ab("multi_r34", OSEL_R3, OSEL_R4, 16'h0006, 16'h0006);
    expect_ab("multi_t12", OSEL_T1, OSEL_T2, 16'h0005, 16'h0005);
    expect_ab("multi_t34", OSEL_T3, OSEL_T4, 16'h0005, 16'h0005);

    // no write bypass on R3
    do_op(FUNSEL_LOAD, 4'b0100, 4'b0000, 16'h0010);
    @(negedge clk);
    funsel = FUNSEL_LOAD;
    i      = 16'h0020;
    rsel   = 4'b0100;
    expect_ab("nobypass_pre", OSEL_R3, OSEL_R3, 16'h0010, 16'h0010);
    i      = 16'h7777;
    funsel = FUNSEL_INC;
    #1;
    funsel = FUNSEL_LOAD;
    i      = 16'h0020;
    expect_ab("level_insens", OSEL_R3, OSEL_R3, 16'h0010, 16'h0010);
    @(posedge clk);
    #1;
    model_apply(FUNSEL_LOAD, 4'b0100, 4'b0000, 16'h0020);
    rsel = 4'b0000;
    expect_ab("nobypass_post", OSEL_R3, OSEL_R3, 16'h0020, 16'h0020);

    // reset wins over an increment on the same edge
    do_op(FUNSEL_LOAD, 4'b0000, 4'b0001, 16'h00FF);
    @(negedge clk);
    funsel = FUNSEL_INC;
    tsel   = 4'b0001;
    #4 rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    expect_ab("rst_midop", OSEL_T1, OSEL_R3, 16'h0000, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_apply(FUNSEL_INC, 4'b0000, 4'b0001, 16'h0000);
    tsel = 4'b0000;
    expect_ab("post_rst_inc", OSEL_T1, OSEL_T2, 16'h0001, 16'h0000);

    // table-driven sweep against the model
    for (int v = 0; v < 12; v++) begin
      do_op(vecs[v].fs, vecs[v].rs, vecs[v].ts, vecs[v].d);
      check_model($sformatf("vec%0d", v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
